// File: rtl/sbox_subbytes_engine.sv
// -----------------------------------------------------------------------------
// sbox_subbytes_engine
//
// Multi-cycle AES SubBytes engine. An NUM_BYTES-byte state is substituted LANES
// bytes per beat through composite-field GF((2^4)^2) S-boxes:
//   isomorphic map -> GF((2^4)^2) inversion -> inverse map -> affine.
// The state register is rotated right by LANES bytes each beat, so after
// BEATS = NUM_BYTES/LANES beats every byte has been substituted once and sits
// in its original position again.
//
// Optional feature macro: SBOX_INV_EN
//   defined   : each lane can also run the inverse S-box (inverse affine before
//               the field inversion), selected per block by in_inv.
//   undefined : forward S-box only; in_inv is ignored.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   input block valid
//   in_ready   out  engine can accept a block (high only in IDLE)
//   in_data    in   state, byte i = in_data[8i+7:8i]
//   in_inv     in   1 = inverse S-box (SBOX_INV_EN builds only)
//   out_valid  out  result valid, held until out_ready
//   out_ready  in   downstream accepts the result
//   out_data   out  substituted state, same byte order as in_data
//   busy       out  high while substituting
// -----------------------------------------------------------------------------
module sbox_subbytes_engine #(
    parameter int NUM_BYTES = 16,
    parameter int LANES     = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [8*NUM_BYTES-1:0] in_data,
    input  logic                   in_inv,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [8*NUM_BYTES-1:0] out_data,
    output logic                   busy
);

    localparam int BEATS = NUM_BYTES / LANES;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    // ---------------- GF(2^4), polynomial x^4 + x + 1 ----------------
    function automatic logic [3:0] gf16_mul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] p;
        logic [3:0] aa;
        p  = 4'h0;
        aa = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) p = p ^ aa;
            aa = aa[3] ? ({aa[2:0], 1'b0} ^ 4'h3) : {aa[2:0], 1'b0};
        end
        return p;
    endfunction

    // a^14 = a^-1 for a != 0, and 0 -> 0
    function automatic logic [3:0] gf16_inv(input logic [3:0] a);
        logic [3:0] a2, a4, a8;
        a2 = gf16_mul(a, a);
        a4 = gf16_mul(a2, a2);
        a8 = gf16_mul(a4, a4);
        return gf16_mul(gf16_mul(a8, a4), a2);
    endfunction

    // ---------------- GF((2^4)^2), polynomial y^2 + y + lam ----------------
    function automatic logic [7:0] gfc_mul(input logic [7:0] a, input logic [7:0] b,
                                           input logic [3:0] lam);
        logic [3:0] hh;
        hh = gf16_mul(a[7:4], b[7:4]);
        return {hh ^ gf16_mul(a[7:4], b[3:0]) ^ gf16_mul(a[3:0], b[7:4]),
                gf16_mul(hh, lam) ^ gf16_mul(a[3:0], b[3:0])};
    endfunction

    // (h*y + l)^-1 = (h*y + h + l) / (h^2*lam + h*l + l^2); zero maps to zero
    function automatic logic [7:0] gfc_inv(input logic [7:0] c, input logic [3:0] lam);
        logic [3:0] h, l, di;
        h  = c[7:4];
        l  = c[3:0];
        di = gf16_inv(gf16_mul(gf16_mul(h, h), lam) ^ gf16_mul(h, l) ^ gf16_mul(l, l));
        return {gf16_mul(h, di), gf16_mul(h ^ l, di)};
    endfunction

    // ---------------- Elaboration-time construction of the isomorphism ----------------
    // Smallest lam for which y^2 + y + lam has no root in GF(2^4).
    function automatic logic [3:0] find_lambda();
        logic [3:0] lam;
        logic       found, has_root;
        lam   = 4'h0;
        found = 1'b0;
        for (int l = 1; l < 16; l++) begin
            has_root = 1'b0;
            for (int t = 0; t < 16; t++)
                if ((gf16_mul(4'(t), 4'(t)) ^ 4'(t)) == 4'(l)) has_root = 1'b1;
            if (!has_root && !found) begin
                lam   = 4'(l);
                found = 1'b1;
            end
        end
        return lam;
    endfunction

    // A root of the AES polynomial x^8 + x^4 + x^3 + x + 1 in the composite field.
    function automatic logic [7:0] find_beta(input logic [3:0] lam);
        logic [7:0] beta, pw, acc;
        logic       found;
        beta  = 8'h0;
        found = 1'b0;
        for (int c = 2; c < 256; c++) begin
            pw  = 8'h01;
            acc = 8'h00;
            for (int k = 0; k <= 8; k++) begin
                if (k == 0 || k == 1 || k == 3 || k == 4 || k == 8) acc = acc ^ pw;
                pw = gfc_mul(pw, 8'(c), lam);
            end
            if (acc == 8'h00 && !found) begin
                beta  = 8'(c);
                found = 1'b1;
            end
        end
        return beta;
    endfunction

    // Linear map stored as eight 8-bit columns; column i is the image of bit i.
    function automatic logic [7:0] apply_lin(input logic [63:0] m, input logic [7:0] x);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 0; i < 8; i++)
            if (x[i]) r = r ^ m[8*i +: 8];
        return r;
    endfunction

    // AES basis alpha^i maps to beta^i.
    function automatic logic [63:0] build_map(input logic [7:0] beta, input logic [3:0] lam);
        logic [63:0] m;
        logic [7:0]  pw;
        m  = '0;
        pw = 8'h01;
        for (int i = 0; i < 8; i++) begin
            m[8*i +: 8] = pw;
            pw          = gfc_mul(pw, beta, lam);
        end
        return m;
    endfunction

    // Column j of the inverse is the preimage of composite basis bit j.
    function automatic logic [63:0] build_imap(input logic [63:0] m);
        logic [63:0] r;
        r = '0;
        for (int j = 0; j < 8; j++)
            for (int a = 0; a < 256; a++)
                if (apply_lin(m, 8'(a)) == (8'h01 << j)) r[8*j +: 8] = 8'(a);
        return r;
    endfunction

    localparam logic [3:0]  LAMBDA = find_lambda();
    localparam logic [7:0]  BETA   = find_beta(LAMBDA);
    localparam logic [63:0] MAP_M  = build_map(BETA, LAMBDA);
    localparam logic [63:0] IMAP_M = build_imap(MAP_M);

    function automatic logic [7:0] gf256_inv(input logic [7:0] x);
        return apply_lin(IMAP_M, gfc_inv(apply_lin(MAP_M, x), LAMBDA));
    endfunction

    function automatic logic [7:0] fwd_affine(input logic [7:0] a);
        return a ^ {a[6:0], a[7]} ^ {a[5:0], a[7:6]} ^ {a[4:0], a[7:5]}
                 ^ {a[3:0], a[7:4]} ^ 8'h63;
    endfunction

`ifdef SBOX_INV_EN
    function automatic logic [7:0] inv_affine(input logic [7:0] b);
        return {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
    endfunction

    function automatic logic [7:0] sbox_lane(input logic [7:0] x, input logic inv);
        logic [7:0] y;
        y = gf256_inv(inv ? inv_affine(x) : x);
        return inv ? y : fwd_affine(y);
    endfunction

    logic inv_reg;
`else
    function automatic logic [7:0] sbox_lane(input logic [7:0] x);
        return fwd_affine(gf256_inv(x));
    endfunction

    logic unused_in_inv;
    assign unused_in_inv = in_inv;
`endif

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                 state;
    logic [8*NUM_BYTES-1:0] state_reg;
    logic [CNT_W-1:0]       cnt;
    logic [8*LANES-1:0]     sub_bytes;
    logic [8*NUM_BYTES-1:0] rot_next;

    always_comb begin
        // NOTE: default first so every path assigns sub_bytes and no latch is inferred.
        sub_bytes = '0;
        for (int i = 0; i < LANES; i++) begin
`ifdef SBOX_INV_EN
            sub_bytes[8*i +: 8] = sbox_lane(state_reg[8*i +: 8], inv_reg);
`else
            sub_bytes[8*i +: 8] = sbox_lane(state_reg[8*i +: 8]);
`endif
        end
    end

    // Substituted low bytes go to the top; with a single beat the rotate is the identity.
    generate
        if (LANES == NUM_BYTES) begin : g_no_rot
            assign rot_next = sub_bytes;
        end else begin : g_rot
            assign rot_next = {sub_bytes, state_reg[8*NUM_BYTES-1:8*LANES]};
        end
    endgenerate

    assign out_data = state_reg;

    // NOTE: all state here uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            state_reg <= '0;
            cnt       <= '0;
`ifdef SBOX_INV_EN
            inv_reg   <= 1'b0;
`endif
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    state_reg <= in_data;
`ifdef SBOX_INV_EN
                    inv_reg   <= in_inv;
`endif
                    cnt       <= '0;
                    state     <= BUSY;
                    in_ready  <= 1'b0;
                    busy      <= 1'b1;
                end
                BUSY: begin
                    state_reg <= rot_next;
                    if (cnt == CNT_W'(BEATS - 1)) begin
                        cnt       <= '0;
                        state     <= DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: if (out_ready) begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sbox_subbytes_engine.sv
// -----------------------------------------------------------------------------
// tb_sbox_subbytes_engine
//
// Directed bench for sbox_subbytes_engine. Main instance uses LANES=4; four
// extra instances (LANES=1,2,8,16) share a second stimulus set for the sweep.
// Expected values come from hand-written S-box constants and from an
// independent reference model (x^254 in GF(2^8) plus the bitwise affine).
// Latency is counted in rising edges, the accepting edge counted as the first.
// -----------------------------------------------------------------------------
module tb_sbox_subbytes_engine;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         in_inv;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;

    logic         sw_in_valid;
    logic [127:0] sw_in_data;
    logic         sw_out_ready;
    logic         sw_in_ready  [4];
    logic         sw_out_valid [4];
    logic [127:0] sw_out_data  [4];
    logic         sw_busy      [4];

    int n_vec = 0;
    int n_err = 0;

    sbox_subbytes_engine #(.NUM_BYTES(16), .LANES(4)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_inv    (in_inv),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    // Sweep instances: g=0..3 -> LANES 1, 2, 8, 16.
    for (genvar g = 0; g < 4; g++) begin : g_sw
        localparam int LN = (g < 2) ? (1 << g) : (1 << (g + 1));
        sbox_subbytes_engine #(.NUM_BYTES(16), .LANES(LN)) u_sw (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (sw_in_valid),
            .in_ready  (sw_in_ready[g]),
            .in_data   (sw_in_data),
            .in_inv    (1'b0),
            .out_valid (sw_out_valid[g]),
            .out_ready (sw_out_ready),
            .out_data  (sw_out_data[g]),
            .busy      (sw_busy[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] ref_sbox(input logic [7:0] x);
        logic [7:0] sq, r, b, c;
        sq = x;
        r  = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq = gmul(sq, sq);
            r  = gmul(r, sq);
        end
        c = 8'h63;
        for (int i = 0; i < 8; i++)
            b[i] = r[i] ^ r[(i + 4) % 8] ^ r[(i + 5) % 8] ^ r[(i + 6) % 8] ^ r[(i + 7) % 8] ^ c[i];
        return b;
    endfunction

    function automatic logic [127:0] ref_state(input logic [127:0] s);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = ref_sbox(s[8*i +: 8]);
        return r;
    endfunction

    function automatic logic [127:0] rep4(input logic [7:0] b0, input logic [7:0] b1,
                                          input logic [7:0] b2, input logic [7:0] b3);
        logic [127:0] r;
        for (int i = 0; i < 16; i += 4) r[8*i +: 32] = {b3, b2, b1, b0};
        return r;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one block to the main instance (which must be idle), waits for
    // the result and completes the output handshake.
    task automatic run_block(input logic [127:0] d, input logic inv,
                             output logic [127:0] res, output int lat);
        in_data  = d;
        in_inv   = inv;
        in_valid = 1'b1;
        tick();
        lat      = 1;
        in_valid = 1'b0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        if (!out_valid) begin
            n_vec++;
            n_err++;
            $display("FAIL run_block_timeout: out_valid=%b after %0d edges, need 1", out_valid, lat);
        end
        res       = out_data;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        n_vec++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_vec++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_vec++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_vec++;
        if (out_data !== 128'h0) begin n_err++; $display("FAIL reset_out_data: got %h want 0", out_data); end
        n_vec++;
        if (sw_in_ready[0] !== 1'b1 || sw_out_valid[3] !== 1'b0 || sw_busy[2] !== 1'b0) begin
            n_err++;
            $display("FAIL reset_sweep: in_ready=%b out_valid=%b busy=%b want 1 0 0",
                     sw_in_ready[0], sw_out_valid[3], sw_busy[2]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    // T1: all-zero state, forward, latency BEATS+1 = 5.
    task automatic test_zero();
        logic [127:0] res;
        int           lat;
        in_data  = '0;
        in_inv   = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n_vec++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL zero_busy_after_accept: busy=%b in_ready=%b want 1 0", busy, in_ready);
        end
        lat = 1;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        res = out_data;
        n_vec++;
        if (lat !== 5) begin n_err++; $display("FAIL zero_latency: got %0d edges want 5", lat); end
        n_vec++;
        if (res !== {16{8'h63}}) begin n_err++; $display("FAIL zero_data: got %h want all 63", res); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    // T2: known byte patterns, checks values and byte positions.
    task automatic test_pattern();
        logic [7:0]   src_b [16] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h10, 8'h11, 8'h53, 8'hFF,
                                     8'hFF, 8'h53, 8'h11, 8'h10, 8'h03, 8'h02, 8'h01, 8'h00};
        logic [7:0]   exp_b [16] = '{8'h63, 8'h7C, 8'h77, 8'h7B, 8'hCA, 8'h82, 8'hED, 8'h16,
                                     8'h16, 8'hED, 8'h82, 8'hCA, 8'h7B, 8'h77, 8'h7C, 8'h63};
        logic [127:0] d, e, res;
        int           lat;
        run_block(rep4(8'h00, 8'h01, 8'h53, 8'hFF), 1'b0, res, lat);
        n_vec++;
        if (res !== rep4(8'h63, 8'h7C, 8'hED, 8'h16)) begin
            n_err++;
            $display("FAIL pattern_rep4: got %h want %h", res, rep4(8'h63, 8'h7C, 8'hED, 8'h16));
        end
        for (int i = 0; i < 16; i++) begin
            d[8*i +: 8] = src_b[i];
            e[8*i +: 8] = exp_b[i];
        end
        run_block(d, 1'b0, res, lat);
        n_vec++;
        if (res !== e) begin n_err++; $display("FAIL pattern_positions: got %h want %h", res, e); end
    endtask

    // T3: hold out_ready low in DONE; new in_valid waits for the handshake.
    task automatic test_backpressure();
        logic [127:0] d1, d2, res;
        int           lat;
        d1       = rep4(8'h01, 8'h02, 8'h03, 8'h10);
        d2       = rep4(8'h11, 8'h00, 8'hFF, 8'h53);
        in_data  = d1;
        in_inv   = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat      = 1;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        in_data  = d2;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_vec++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== rep4(8'h7C, 8'h77, 8'h7B, 8'hCA)) begin
                n_err++;
                $display("FAIL hold_cycle%0d: out_valid=%b in_ready=%b data=%h want 1 0 %h",
                         i, out_valid, in_ready, out_data, rep4(8'h7C, 8'h77, 8'h7B, 8'hCA));
            end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_vec++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL after_handshake: in_ready=%b busy=%b out_valid=%b want 1 0 0",
                     in_ready, busy, out_valid);
        end
        tick();
        in_valid = 1'b0;
        n_vec++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL accept_after_handshake: busy=%b want 1", busy); end
        lat = 1;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        res = out_data;
        n_vec++;
        if (res !== rep4(8'h82, 8'h63, 8'h16, 8'hED)) begin
            n_err++;
            $display("FAIL second_block: got %h want %h", res, rep4(8'h82, 8'h63, 8'h16, 8'hED));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    // T4: reset while BUSY with cnt=2, then a clean block.
    task automatic test_mid_reset();
        logic [127:0] res;
        int           lat;
        in_data  = rep4(8'h53, 8'h53, 8'h53, 8'h53);
        in_inv   = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        n_vec++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL midrst_pre_busy: got %b want 1", busy); end
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_outputs: in_ready=%b out_valid=%b busy=%b want 1 0 0",
                     in_ready, out_valid, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        run_block(rep4(8'hFF, 8'h00, 8'h01, 8'h02), 1'b0, res, lat);
        n_vec++;
        if (res !== rep4(8'h16, 8'h63, 8'h7C, 8'h77) || lat !== 5) begin
            n_err++;
            $display("FAIL midrst_next_block: got %h lat %0d want %h lat 5",
                     res, lat, rep4(8'h16, 8'h63, 8'h7C, 8'h77));
        end
    endtask

    // Back-to-back with in_valid and out_ready held high: one block per 6 cycles.
    task automatic test_back_to_back();
        logic [127:0] da, db, ra, rb;
        int           first, second, got_a, lat;
        logic         acc;
        da        = {32'h0011_2233, 32'h4455_6677, 32'h8899_AABB, 32'hCCDD_EEFF};
        db        = {32'hDEAD_BEEF, 32'h0123_4567, 32'h89AB_CDEF, 32'hF0E1_D2C3};
        ra        = '0;
        rb        = '0;
        first     = -1;
        second    = -1;
        got_a     = 0;
        out_ready = 1'b1;
        in_data   = da;
        in_inv    = 1'b0;
        in_valid  = 1'b1;
        for (int e = 0; e < 30 && second < 0; e++) begin
            acc = in_ready && in_valid;
            tick();
            if (acc) begin
                if (first < 0) begin
                    first   = e;
                    in_data = db;
                end else begin
                    second   = e;
                    in_valid = 1'b0;
                end
            end
            if (out_valid && got_a == 0) begin
                ra    = out_data;
                got_a = 1;
            end
        end
        in_valid = 1'b0;
        n_vec++;
        if (second - first !== 6) begin
            n_err++;
            $display("FAIL b2b_period: got %0d cycles want 6", second - first);
        end
        n_vec++;
        if (ra !== ref_state(da)) begin n_err++; $display("FAIL b2b_block_a: got %h want %h", ra, ref_state(da)); end
        lat = 1;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        rb = out_data;
        n_vec++;
        if (rb !== ref_state(db)) begin n_err++; $display("FAIL b2b_block_b: got %h want %h", rb, ref_state(db)); end
        tick();
        out_ready = 1'b0;
    endtask

`ifdef SBOX_INV_EN
    // T5: inverse S-box and a 256-value forward/inverse round trip.
    task automatic test_inverse();
        logic [127:0] d, f, back;
        int           lat, bad;
        run_block(rep4(8'h63, 8'hED, 8'h16, 8'h7C), 1'b1, back, lat);
        n_vec++;
        if (back !== rep4(8'h00, 8'h53, 8'hFF, 8'h01)) begin
            n_err++;
            $display("FAIL inverse_vectors: got %h want %h", back, rep4(8'h00, 8'h53, 8'hFF, 8'h01));
        end
        bad = 0;
        for (int blk = 0; blk < 16; blk++) begin
            for (int i = 0; i < 16; i++) d[8*i +: 8] = 8'(blk * 16 + i);
            run_block(d, 1'b0, f, lat);
            run_block(f, 1'b1, back, lat);
            n_vec++;
            if (back !== d || f !== ref_state(d)) begin
                n_err++;
                bad++;
                $display("FAIL roundtrip_blk%0d: fwd %h back %h want fwd %h back %h",
                         blk, f, back, ref_state(d), d);
            end
        end
    endtask
`else
    // Without the inverse option, in_inv must have no effect.
    task automatic test_inverse();
        logic [127:0] res;
        int           lat;
        run_block(rep4(8'h00, 8'h01, 8'h53, 8'hFF), 1'b1, res, lat);
        n_vec++;
        if (res !== rep4(8'h63, 8'h7C, 8'hED, 8'h16)) begin
            n_err++;
            $display("FAIL inv_ignored: got %h want %h", res, rep4(8'h63, 8'h7C, 8'hED, 8'h16));
        end
    endtask
`endif

    // T6: LANES = 1, 2, 8, 16 against the reference model, latency BEATS+1.
    task automatic test_lanes_sweep();
        logic [127:0] d;
        logic [127:0] res  [4];
        int           lat  [4];
        logic         seen [4];
        int           beats;
        for (int r = 0; r < 2; r++) begin
            d           = {$urandom(), $urandom(), $urandom(), $urandom()};
            sw_in_data  = d;
            sw_in_valid = 1'b1;
            tick();
            sw_in_valid = 1'b0;
            for (int g = 0; g < 4; g++) begin
                seen[g] = 1'b0;
                lat[g]  = 0;
                res[g]  = '0;
            end
            for (int c = 1; c <= 40; c++) begin
                if (c > 1) tick();
                for (int g = 0; g < 4; g++) begin
                    if (!seen[g] && sw_out_valid[g]) begin
                        seen[g] = 1'b1;
                        lat[g]  = c;
                        res[g]  = sw_out_data[g];
                    end
                end
            end
            for (int g = 0; g < 4; g++) begin
                beats = 16 / ((g < 2) ? (1 << g) : (1 << (g + 1)));
                n_vec++;
                if (!seen[g] || lat[g] !== beats + 1) begin
                    n_err++;
                    $display("FAIL sweep%0d_g%0d_latency: seen=%b got %0d want %0d", r, g, seen[g], lat[g], beats + 1);
                end
                n_vec++;
                if (res[g] !== ref_state(d)) begin
                    n_err++;
                    $display("FAIL sweep%0d_g%0d_data: got %h want %h", r, g, res[g], ref_state(d));
                end
            end
            sw_out_ready = 1'b1;
            tick();
            sw_out_ready = 1'b0;
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        in_data      = '0;
        in_inv       = 1'b0;
        out_ready    = 1'b0;
        sw_in_valid  = 1'b0;
        sw_in_data   = '0;
        sw_out_ready = 1'b0;
        test_reset();
        test_zero();
        test_pattern();
        test_backpressure();
        test_mid_reset();
        test_back_to_back();
        test_inverse();
        test_lanes_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
